// File: rtl/dpi_stream_ctx_counter.sv
// dpi_stream_ctx_counter: per-stream DFA context save/restore with speculative match commit and saturating counts.
// Define DPI_PER_STREAM_CNT_EN to add the per-stream count RAM and rd_count readback.
module dpi_stream_ctx_counter #(
  parameter int STATE_W = 11,
  parameter int SID_W = 6,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_state,
  input  logic new_stream_id,
  input  logic [SID_W-1:0] stream_id,
  input  logic enable,
  input  logic eop,
  input  logic [STATE_W-1:0] eng_state_out,
  input  logic eng_accept,
  output logic [STATE_W-1:0] eng_state_in,
  output logic eng_state_in_vld,
  output logic fired,
  output logic [CNT_W-1:0] count,
  output logic proto_err,
  input  logic [SID_W-1:0] rd_sid,
  output logic [CNT_W-1:0] rd_count
);
  localparam int DEPTH = 2**SID_W;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;
  logic [SID_W-1:0] cur_sid;
  logic [DEPTH-1:0] valid;
  logic [STATE_W-1:0] ctx_mem [DEPTH];
  logic active, commit, drop, err_set, fired_eff, fwd;
  logic [STATE_W-1:0] load_val;
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nxt;
  always_comb state_nxt = load_state ? ACTIVE : (state == ACTIVE && eop) ? IDLE : state;
  // A commit and a reload of the same stream in one edge must see the state being written.
  always_comb begin
    active = state == ACTIVE;
    fired_eff = fired | eng_accept;
    commit = active & eop & enable;
    drop = active & eop & ~enable;
    err_set = active ? load_state & ~eop : eop;
    fwd = commit && stream_id == cur_sid;
    load_val = new_stream_id ? '0 : fwd ? eng_state_out : valid[stream_id] ? ctx_mem[stream_id] : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      fired <= 1'b0;
      proto_err <= 1'b0;
      eng_state_in_vld <= 1'b0;
      eng_state_in <= '0;
      valid <= '0;
      cur_sid <= '0;
    end else begin
      eng_state_in_vld <= load_state;
      if (load_state) begin
        cur_sid <= stream_id;
        eng_state_in <= load_val;
      end
      fired <= (load_state || drop) ? 1'b0 : (active && eng_accept) ? 1'b1 : fired;
      if (err_set) proto_err <= 1'b1;
      if (commit && fired_eff && count != '1) count <= count + CNT_W'(1);
      if (commit) valid[cur_sid] <= 1'b1;
    end
  end
  always_ff @(posedge clk) if (rst_n && commit) ctx_mem[cur_sid] <= eng_state_out;
`ifdef DPI_PER_STREAM_CNT_EN
  logic [CNT_W-1:0] cnt_mem [DEPTH];
  logic [CNT_W-1:0] cnt_cur;
  assign cnt_cur = cnt_mem[cur_sid];
  // Entries are not reset; an invalid stream's first commit overwrites stale contents.
  always_ff @(posedge clk) begin
    if (rst_n && commit && (!valid[cur_sid] || (fired_eff && cnt_cur != '1)))
      cnt_mem[cur_sid] <= valid[cur_sid] ? cnt_cur + CNT_W'(1) : CNT_W'(fired_eff);
    rd_count <= (rst_n && valid[rd_sid]) ? cnt_mem[rd_sid] : '0;
  end
`else
  logic unused_rd_sid;
  assign unused_rd_sid = ^rd_sid;
  assign rd_count = '0;
`endif
endmodule

// File: tb/tb_dpi_stream_ctx_counter.sv
// tb_dpi_stream_ctx_counter: randomized + directed stimulus against a behavioural model, with a queue-based scoreboard.
module tb_dpi_stream_ctx_counter;
`ifdef DPI_PER_STREAM_CNT_EN
  localparam bit PS = 1'b1;
`else
  localparam bit PS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, load_state, new_stream_id, enable, eop, eng_accept;
  logic [5:0] stream_id, rd_sid;
  logic [10:0] eng_state_out, eng_state_in;
  logic eng_state_in_vld, fired, proto_err;
  logic [15:0] count, rd_count;
  always #5 clk = ~clk;
  dpi_stream_ctx_counter dut (
    .clk(clk), .rst_n(rst_n), .load_state(load_state), .new_stream_id(new_stream_id),
    .stream_id(stream_id), .enable(enable), .eop(eop), .eng_state_out(eng_state_out),
    .eng_accept(eng_accept), .eng_state_in(eng_state_in), .eng_state_in_vld(eng_state_in_vld),
    .fired(fired), .count(count), .proto_err(proto_err), .rd_sid(rd_sid), .rd_count(rd_count)
  );
  typedef struct {
    logic vld;
    logic [10:0] si;
    logic [15:0] cnt;
    logic fired;
    logic perr;
    logic [15:0] rdc;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  bit m_act, m_fired, m_perr;
  bit [5:0] m_sid;
  bit [15:0] m_cnt;
  bit [10:0] m_si;
  bit m_vld [64];
  bit [10:0] m_ctx [64];
  bit [15:0] m_pcnt [64];
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("eng_state_in_vld", 32'(eng_state_in_vld), 32'(e.vld));
      if (e.vld) chk("eng_state_in", 32'(eng_state_in), 32'(e.si));
      chk("count", 32'(count), 32'(e.cnt));
      chk("fired", 32'(fired), 32'(e.fired));
      chk("proto_err", 32'(proto_err), 32'(e.perr));
      chk("rd_count", 32'(rd_count), 32'(e.rdc));
    end
  end
  // One clock edge: advance the reference model, then queue what the DUT must show after the edge.
  task automatic cyc();
    exp_t e;
    bit fe;
    bit [15:0] rdc;
    rdc = (PS && m_vld[rd_sid]) ? m_pcnt[rd_sid] : 16'h0;
    e.vld = 1'b0;
    if (!rst_n) begin
      m_act = 0; m_cnt = 0; m_fired = 0; m_perr = 0; rdc = 0;
      foreach (m_vld[i]) m_vld[i] = 0;
    end else begin
      fe = m_fired | eng_accept;
      if (m_act ? (load_state && !eop) : eop) m_perr = 1;
      if (m_act && eop && enable) begin
        if (fe && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        if (!m_vld[m_sid]) m_pcnt[m_sid] = 16'(fe);
        else if (fe && m_pcnt[m_sid] != 16'hFFFF) m_pcnt[m_sid] = m_pcnt[m_sid] + 1;
        m_ctx[m_sid] = eng_state_out;
        m_vld[m_sid] = 1;
      end
      if (load_state) m_fired = 0;
      else if (m_act && eop && !enable) m_fired = 0;
      else if (m_act && eng_accept) m_fired = 1;
      e.vld = load_state;
      if (load_state) begin
        m_si = new_stream_id ? 11'h0 : m_vld[stream_id] ? m_ctx[stream_id] : 11'h0;
        m_sid = stream_id;
      end
      m_act = load_state ? 1'b1 : (m_act && eop) ? 1'b0 : m_act;
    end
    e.si = m_si; e.cnt = m_cnt; e.fired = m_fired; e.perr = m_perr; e.rdc = rdc;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask
  task automatic idle_in();
    load_state = 0; new_stream_id = 0; eop = 0; enable = 0; eng_accept = 0;
  endtask
  task automatic load(input logic [5:0] sid, input logic nw);
    load_state = 1; stream_id = sid; new_stream_id = nw;
    cyc();
    idle_in();
  endtask
  task automatic end_pkt(input logic en, input logic [10:0] st, input logic acc);
    eop = 1; enable = en; eng_state_out = st; eng_accept = acc;
    cyc();
    idle_in();
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 0; idle_in(); stream_id = 0; rd_sid = 0; eng_state_out = 0;
    @(negedge clk);
    cyc(); cyc();
    rst_n = 1;
    load(6'd5, 1'b1); cyc();
    eng_accept = 1; cyc(); idle_in();
    end_pkt(1'b1, 11'h02A, 1'b0);
    load(6'd5, 1'b0); cyc();
    eng_accept = 1; cyc(); idle_in();
    end_pkt(1'b0, 11'h055, 1'b0);
    load(6'd5, 1'b0); cyc();
    eop = 1; enable = 1; eng_state_out = 11'h011; eng_accept = 1;
    load_state = 1; stream_id = 5; new_stream_id = 0;
    cyc(); idle_in(); cyc();
    load(6'd7, 1'b1);
    load(6'd8, 1'b1);
    cyc();
    end_pkt(1'b1, 11'h003, 1'b1);
    rst_n = 0; cyc(); rst_n = 1;
    end_pkt(1'b1, 11'h004, 1'b1);
    cyc(); cyc();
    rst_n = 0; cyc(); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      load(6'd9, 1'b0);
      eng_accept = 1; cyc(); idle_in();
      end_pkt(1'b1, 11'(i), 1'b0);
    end
    rd_sid = 9; cyc(); cyc();
    load(6'd3, 1'b1);
    for (int i = 0; i < 65540; i++) begin
      eop = 1; enable = 1; eng_accept = 1; load_state = 1; stream_id = 3;
      eng_state_out = 11'(i); rd_sid = 3;
      cyc();
    end
    idle_in();
    end_pkt(1'b1, 11'h001, 1'b1);
    cyc();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      load_state = ($urandom_range(0, 3) == 0);
      new_stream_id = ($urandom_range(0, 3) == 0);
      stream_id = 6'($urandom_range(0, 7));
      enable = ($urandom_range(0, 4) != 0);
      eop = ($urandom_range(0, 2) == 0);
      eng_accept = ($urandom_range(0, 3) == 0);
      eng_state_out = 11'($urandom);
      rd_sid = 6'($urandom_range(0, 7));
      cyc();
    end
    rst_n = 1; idle_in();
    cyc(); cyc();
    @(negedge clk); #1;
    chk("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
